psg_bus_writer: RTL and testbench
=================================

Name: psg_bus_writer

Overview:
- Host-side write sequencer for the SN76489-compatible PSG byte bus: the transmitter for the PSG's /WE + 8-bit data receiver.
- Accepts register-level commands (register select + value) over a valid/ready handshake and buffers them in a small FIFO.
- Encodes each command into the latch byte and, where needed, the data byte, then drives the bus with correctly timed active-low /WE strobes.
- Sits between a sequencer/CPU and the PSG's ui_in / uio_in[0] pins.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, >= 2).
- WE_CYCLES, 1, clocks psg_we_n is held low per byte (>= 1).
- GAP_CYCLES, 1, clocks psg_we_n is held high after each byte before the next strobe (>= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command (= !full).
- cmd_reg  in  3  PSG register: 000/010/100 tone0-2 freq, 110 noise, 001/011/101/111 attn0-3.
- cmd_value  in  10  value; tone uses [9:0], noise [2:0], attn [3:0].
- psg_data  out  8  byte to the PSG data bus.
- psg_we_n  out  1  active-low write strobe.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, synchronous-style release on clk):
  - psg_we_n=1, psg_data=0, FIFO emptied, fifo_level=0, busy=0, FSM=IDLE.
  - cmd_ready=1 once out of reset.
- Push: a command is stored on a clk edge where cmd_valid && cmd_ready. There is no push-through: cmd_ready depends only on fifo_level, so a full FIFO holds cmd_ready=0 even in a cycle that pops.
- Encoding:
  - Latch byte = {1, cmd_reg[2:0], low nibble}.
    - Tone: low nibble = value[3:0].
    - Noise: low nibble = {0, value[2:0]}.
    - Attn: low nibble = value[3:0].
  - Data byte (tone only) = {00, value[9:4]}.
  - Noise and attn are single-byte commands; tone is two bytes.
- FSM states: IDLE, LATCH, GAP1, DATA, GAP2.
  - IDLE: if FIFO non-empty, pop the head into the working register; go to LATCH next edge.
  - LATCH: psg_data=latch byte, psg_we_n=0 for WE_CYCLES clocks, then go to GAP1.
  - GAP1: psg_we_n=1, psg_data held, for GAP_CYCLES clocks. Then go to DATA if two-byte, else IDLE.
  - DATA: psg_data=data byte, psg_we_n=0 for WE_CYCLES clocks, then go to GAP2.
  - GAP2: psg_we_n=1 for GAP_CYCLES clocks, then go to IDLE.
- Outputs are registered: psg_data never changes in the same cycle that psg_we_n is low unless the byte itself changes between strobes.
- Latency: command accepted on edge k into an empty FIFO with FSM idle → pop on edge k+1 → psg_we_n low starting after edge k+2.
- Byte spacing: consecutive strobes are separated by exactly GAP_CYCLES high clocks plus one IDLE clock between commands.
- Simultaneous push and pop: allowed when not full. fifo_level is unchanged and FIFO order is preserved.
- Pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by the occupancy count.
- Reset mid-operation: psg_we_n deasserts immediately (asynchronous) and any partial two-byte write is abandoned. The PSG may hold a new low nibble only, which is acceptable.
- cmd_value bits unused by the selected register are ignored.

Optional Feature:
- Macro: PSG_SKIP_REDUNDANT_EN.
- Defined:
  - Three 6-bit shadow registers plus valid flags store the last high-6 bits written per tone channel.
  - A tone command whose value[9:4] equals a valid shadow emits only the latch byte; GAP1 then goes to IDLE.
  - Shadows update when the DATA byte is strobed. Valid flags clear on reset, so the first write per tone is always two bytes.
- Undefined: every tone command emits two bytes. No shadow logic is present.

Test Plan:
- Tone0 value 0x3FE → psg_data 0x8E with one we_n-low clock, one high clock, then 0x3F with one low clock; busy falls after GAP2.
- Attn3 value 0x00F → single strobe 0xFF. Noise value 0x005 → single strobe 0xE5. No DATA state is visited.
- Push 6 commands back-to-back from empty (depth 4) → cmd_ready=0 when fifo_level reaches 4 (the 6th push stalls until a pop frees an entry); all 6 are emitted in order with correct bytes.
- Reset asserted during LATCH of a tone write → psg_we_n=1 in the same cycle; after release fifo_level=0, busy=0, no further strobes.
- WE_CYCLES=3, GAP_CYCLES=2, tone1 value 0x123 → 0xA3 low for 3 clocks, high 2, 0x12 low 3, high 2.
- With PSG_SKIP_REDUNDANT_EN, tone1 0x123 twice → first write emits 0xA3, 0x12; second emits 0xA3 only. A third write of 0x223 emits 0xA3, 0x22. Without the macro, all three writes emit two bytes.

Source files
------------

// File: rtl/psg_bus_writer.sv
// Command FIFO plus byte sequencer that drives SN76489-style /WE + 8-bit data writes.
// Optional macro PSG_SKIP_REDUNDANT_EN drops tone data bytes that would repeat the last write.
module psg_bus_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WE_CYCLES  = 1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_reg,
    input  logic [9:0]                    cmd_value,
    output logic [7:0]                    psg_data,
    output logic                          psg_we_n,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = 13;
    localparam int unsigned MAX_C = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0] WE_LOAD  = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP1, S_DATA, S_GAP2} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level_nxt;
    logic               push, pop, last, to_idle, idle_nxt;
    logic [2:0]         head_reg;
    logic [9:0]         head_val;
    logic               head_tone, head_skip;
    logic [7:0]         head_latch, head_data;
    logic [7:0]         work_latch, work_data;
    logic               work_two;

    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (fifo_level != '0);
    assign level_nxt = fifo_level + LVL_W'(push) - LVL_W'(pop);

    // Command encoding of the FIFO head
    assign head_reg   = fifo_mem[rd_ptr][12:10];
    assign head_val   = fifo_mem[rd_ptr][9:0];
    assign head_tone  = !head_reg[0] && (head_reg[2:1] != 2'b11);
    assign head_latch = (head_reg == 3'b110) ? {1'b1, head_reg, 1'b0, head_val[2:0]}
                                             : {1'b1, head_reg, head_val[3:0]};
    assign head_data  = {2'b00, head_val[9:4]};

    assign last     = (cnt == '0);
    assign to_idle  = ((state == S_GAP1) && last && !work_two) || ((state == S_GAP2) && last);
    assign idle_nxt = ((state == S_IDLE) && !pop) || to_idle;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_reg, cmd_value};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= level_nxt;
        end
    end

    // Sequencer; bus outputs follow the state by one clock so strobe widths equal state durations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            work_latch <= '0;
            work_data  <= '0;
            work_two   <= 1'b0;
            psg_we_n   <= 1'b1;
            psg_data   <= '0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            busy      <= (level_nxt != '0) || !idle_nxt;
            cmd_ready <= (level_nxt != LVL_FULL);
            psg_we_n  <= !((state == S_LATCH) || (state == S_DATA));
            if (state == S_LATCH) psg_data <= work_latch;
            if (state == S_DATA)  psg_data <= work_data;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        work_latch <= head_latch;
                        work_data  <= head_data;
                        work_two   <= head_tone && !head_skip;
                        cnt        <= WE_LOAD;
                        state      <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (last) begin
                        cnt   <= GAP_LOAD;
                        state <= S_GAP1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_GAP1: begin
                    if (last) begin
                        cnt   <= WE_LOAD;
                        state <= work_two ? S_DATA : S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (last) begin
                        cnt   <= GAP_LOAD;
                        state <= S_GAP2;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_GAP2: begin
                    if (last) state <= S_IDLE;
                    else      cnt   <= cnt - CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PSG_SKIP_REDUNDANT_EN
    logic [5:0] shadow [3];
    logic [2:0] shadow_vld;
    logic [1:0] work_ch;

    always_comb begin
        head_skip = 1'b0;
        case (head_reg)
            3'b000:  head_skip = shadow_vld[0] && (shadow[0] == head_val[9:4]);
            3'b010:  head_skip = shadow_vld[1] && (shadow[1] == head_val[9:4]);
            3'b100:  head_skip = shadow_vld[2] && (shadow[2] == head_val[9:4]);
            default: head_skip = 1'b0;
        endcase
    end

    // Shadows track the high bits the PSG actually received
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_vld <= '0;
            work_ch    <= '0;
            for (int i = 0; i < 3; i++) shadow[i] <= '0;
        end else begin
            if (pop) work_ch <= head_reg[2:1];
            if (state == S_DATA) begin
                case (work_ch)
                    2'd0: begin shadow[0] <= work_data[5:0]; shadow_vld[0] <= 1'b1; end
                    2'd1: begin shadow[1] <= work_data[5:0]; shadow_vld[1] <= 1'b1; end
                    2'd2: begin shadow[2] <= work_data[5:0]; shadow_vld[2] <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end
`else
    assign head_skip = 1'b0;
`endif

endmodule

// File: tb/tb_psg_bus_writer.sv
// Scoreboard bench for psg_bus_writer: two instances (1/1 and 3/2 strobe/gap timing).
module tb_psg_bus_writer;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] len;
        logic [7:0] gap;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid  [2];
    logic       cmd_ready  [2];
    logic [2:0] cmd_reg    [2];
    logic [9:0] cmd_value  [2];
    logic [7:0] psg_data   [2];
    logic       psg_we_n   [2];
    logic       busy       [2];
    logic [2:0] fifo_level [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic saw_full = 1'b0;

    logic       in_strb [2];
    logic       stable  [2];
    logic [7:0] cap_d   [2];
    int         low_n   [2];
    int         high_n  [2];
    int         gap_at  [2];

    psg_bus_writer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_reg(cmd_reg[0]), .cmd_value(cmd_value[0]),
        .psg_data(psg_data[0]), .psg_we_n(psg_we_n[0]),
        .busy(busy[0]), .fifo_level(fifo_level[0])
    );

    psg_bus_writer #(.FIFO_DEPTH(4), .WE_CYCLES(3), .GAP_CYCLES(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_reg(cmd_reg[1]), .cmd_value(cmd_value[1]),
        .psg_data(psg_data[1]), .psg_we_n(psg_we_n[1]),
        .busy(busy[1]), .fifo_level(fifo_level[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reconstruct strobes from the bus and compare each against the scoreboard
    task automatic mon_step(input int i, input logic we, input logic [7:0] d);
        exp_t e;
        int   qs;
        if (we == 1'b0) begin
            if (!in_strb[i]) begin
                in_strb[i] = 1'b1;
                cap_d[i]   = d;
                low_n[i]   = 1;
                stable[i]  = 1'b1;
                gap_at[i]  = high_n[i];
            end else begin
                low_n[i]++;
                if (d != cap_d[i]) stable[i] = 1'b0;
            end
        end else if (in_strb[i]) begin
            in_strb[i] = 1'b0;
            high_n[i]  = 1;
            qs = (i == 0) ? q0.size() : q1.size();
            check($sformatf("dut%0d_strobe_expected", i), int'(qs != 0), 1);
            if (qs != 0) begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("dut%0d_byte", i), int'(cap_d[i]), int'(e.data));
                check($sformatf("dut%0d_low_len_%0h", i, e.data), low_n[i], int'(e.len));
                check($sformatf("dut%0d_data_stable_%0h", i, e.data), int'(stable[i]), 1);
                if (e.gap != 0)
                    check($sformatf("dut%0d_gap_before_%0h", i, e.data), gap_at[i], int'(e.gap));
            end
        end else begin
            high_n[i]++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                in_strb[i] = 1'b0;
                stable[i]  = 1'b1;
                cap_d[i]   = '0;
                low_n[i]   = 0;
                high_n[i]  = 100;
                gap_at[i]  = 0;
            end
        end else begin
            mon_step(0, psg_we_n[0], psg_data[0]);
            mon_step(1, psg_we_n[1], psg_data[1]);
            for (int i = 0; i < 2; i++)
                check($sformatf("dut%0d_ready_vs_level", i), int'(cmd_ready[i]), int'(fifo_level[i] != 3'd4));
            if (fifo_level[0] == 3'd4 && !cmd_ready[0]) saw_full = 1'b1;
        end
    end

    // Issue one command; expected bytes go to the scoreboard once the handshake completes
    task automatic push(input int i, input logic [2:0] r, input logic [9:0] v,
                        input logic [7:0] lb, input int lgap, input logic two, input logic [7:0] db);
        logic rdy;
        int   n;
        exp_t e;
        int   len;
        int   dgap;
        len  = (i == 0) ? 1 : 3;
        dgap = (i == 0) ? 1 : 2;
        rdy  = 1'b0;
        n    = 0;
        cmd_valid[i] = 1'b1;
        cmd_reg[i]   = r;
        cmd_value[i] = v;
        for (n = 0; n < 200; n++) begin
            rdy = cmd_ready[i];
            @(posedge clk);
            if (rdy) break;
            #1;
        end
        #1;
        cmd_valid[i] = 1'b0;
        check($sformatf("dut%0d_push_accepted_%0h", i, v), int'(rdy), 1);
        if (rdy) begin
            e.data = lb; e.len = 8'(len); e.gap = 8'(lgap);
            if (i == 0) q0.push_back(e); else q1.push_back(e);
            if (two) begin
                e.data = db; e.len = 8'(len); e.gap = 8'(dgap);
                if (i == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input int i, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_idle_in_time", name), int'(n < 300), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_reg[i]   = '0;
            cmd_value[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_we_n", int'(psg_we_n[0]), 1);
        check("rst_data", int'(psg_data[0]), 0);
        check("rst_level", int'(fifo_level[0]), 0);
        check("rst_busy", int'(busy[0]), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(cmd_ready[0]), 1);
        check("we_n_after_reset", int'(psg_we_n[0]), 1);

        // Tone0 0x3FE with latency check
        push(0, 3'b000, 10'h3FE, 8'h8E, 0, 1'b1, 8'h3F);
        @(negedge clk);
        check("lat_we_n_k", int'(psg_we_n[0]), 1);
        @(negedge clk);
        check("lat_we_n_k1", int'(psg_we_n[0]), 1);
        @(negedge clk);
        check("lat_we_n_k2", int'(psg_we_n[0]), 0);
        check("lat_data_k2", int'(psg_data[0]), 8'h8E);
        wait_idle(0, "tone0");
        #1;
        check("tone0_drained_at_busy_fall", q0.size(), 0);
        check("tone0_we_n_at_busy_fall", int'(psg_we_n[0]), 1);

        // Single-byte commands: attn3 then noise
        push(0, 3'b111, 10'h00F, 8'hFF, 0, 1'b0, 8'h00);
        push(0, 3'b110, 10'h005, 8'hE5, 2, 1'b0, 8'h00);
        wait_idle(0, "attn_noise");
        repeat (3) @(negedge clk);
        #1;
        check("attn_noise_drained", q0.size(), 0);

        // Six back-to-back commands into a depth-4 FIFO
        saw_full = 1'b0;
        push(0, 3'b000, 10'h155, 8'h85, 0, 1'b1, 8'h15);
        push(0, 3'b010, 10'h2AA, 8'hAA, 2, 1'b1, 8'h2A);
        push(0, 3'b100, 10'h001, 8'hC1, 2, 1'b1, 8'h00);
        push(0, 3'b110, 10'h3FF, 8'hE7, 2, 1'b0, 8'h00);
        push(0, 3'b101, 10'h3F0, 8'hD0, 2, 1'b0, 8'h00);
        push(0, 3'b000, 10'h0F0, 8'h80, 2, 1'b1, 8'h0F);
        wait_idle(0, "burst");
        repeat (3) @(negedge clk);
        #1;
        check("burst_saw_full", int'(saw_full), 1);
        check("burst_drained", q0.size(), 0);

        // Reset during the latch strobe of a tone write
        push(0, 3'b100, 10'h3FF, 8'hCF, 0, 1'b1, 8'h3F);
        n = 0;
        @(negedge clk);
        while (psg_we_n[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_strobe_seen", int'(n < 50), 1);
        #2 rst_n = 1'b0;
        q0.delete();
        #1;
        check("rst_mid_we_n_async", int'(psg_we_n[0]), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_level", int'(fifo_level[0]), 0);
        check("rst_mid_busy", int'(busy[0]), 0);
        check("rst_mid_we_n_idle", int'(psg_we_n[0]), 1);

        // Slow-timing instance: tone1 0x123
        push(1, 3'b010, 10'h123, 8'hA3, 0, 1'b1, 8'h12);
        wait_idle(1, "slow_tone1");
        repeat (3) @(negedge clk);
        #1;
        check("slow_drained", q1.size(), 0);

        // Repeated tone1 writes
        push(0, 3'b010, 10'h123, 8'hA3, 0, 1'b1, 8'h12);
`ifdef PSG_SKIP_REDUNDANT_EN
        push(0, 3'b010, 10'h123, 8'hA3, 2, 1'b0, 8'h12);
`else
        push(0, 3'b010, 10'h123, 8'hA3, 2, 1'b1, 8'h12);
`endif
        push(0, 3'b010, 10'h223, 8'hA3, 2, 1'b1, 8'h22);
        wait_idle(0, "repeat_tone1");
        repeat (3) @(negedge clk);
        #1;
        check("repeat_drained", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
